// File: rtl/wb_rr_arbiter2.sv
// wb_rr_arbiter2: two-master round-robin arbiter in front of one Wishbone pipelined slave.
// Transfers are single-beat and strictly one at a time. Each transfer runs IDLE -> ISSUE ->
// WAIT -> RESP. When no ack/err arrives in time, the arbiter ends the transfer with an error.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   m{0,1}_wb_cyc/stb/we_i  master cycle, strobe, write enable
//   m{0,1}_wb_adr/sel/dat_i master word address, byte selects, write data
//   m{0,1}_wb_ack/err_o     one-cycle completion / error pulse to the owning master
//   m{0,1}_wb_stall_o       low only in the cycle that master's request is accepted
//   m{0,1}_wb_dat_o         read data captured from the slave, valid with ack
//   s_wb_cyc/stb/we_o       slave cycle, strobe, write enable
//   s_wb_adr/sel/dat_o      latched address, byte selects, write data
//   s_wb_ack/err/stall_i    slave response and stall
//   s_wb_dat_i              slave read data
module wb_rr_arbiter2 #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    m0_wb_cyc_i,
    input  logic                    m0_wb_stb_i,
    input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
    input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
    input  logic                    m0_wb_we_i,
    input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
    output logic                    m0_wb_ack_o,
    output logic                    m0_wb_err_o,
    output logic                    m0_wb_stall_o,
    output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,
    input  logic                    m1_wb_cyc_i,
    input  logic                    m1_wb_stb_i,
    input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
    input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
    input  logic                    m1_wb_we_i,
    input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
    output logic                    m1_wb_ack_o,
    output logic                    m1_wb_err_o,
    output logic                    m1_wb_stall_o,
    output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,
    output logic                    s_wb_cyc_o,
    output logic                    s_wb_stb_o,
    output logic                    s_wb_we_o,
    output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
    output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
    output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
    input  logic                    s_wb_ack_i,
    input  logic                    s_wb_err_i,
    input  logic                    s_wb_stall_i,
    input  logic [DATA_WIDTH-1:0]   s_wb_dat_i
);

    localparam int unsigned SelWidth = DATA_WIDTH / 8;
    localparam int unsigned CntWidth = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic                  last_q, last_d;    // master granted most recently (1 = m1)
    logic                  owner_q, owner_d;
    logic                  resp_err_q, resp_err_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [SelWidth-1:0]   sel_q, sel_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;

    logic req0, req1, grant0, grant1, idle;

    always_comb begin
        req0   = m0_wb_cyc_i & m0_wb_stb_i;
        req1   = m1_wb_cyc_i & m1_wb_stb_i;
        // Under contention the master that was not served last wins. Grants are held off
        // while reset is asserted so both masters see stall during reset.
        grant0 = rst_n_i & req0 & (~req1 | last_q);
        grant1 = rst_n_i & req1 & (~req0 | ~last_q);
        idle   = (state_q == StIdle);
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        resp_err_d = resp_err_q;
        we_d       = we_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        rdat_d     = rdat_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    last_d  = grant1;
                    we_d    = grant1 ? m1_wb_we_i  : m0_wb_we_i;
                    adr_d   = grant1 ? m1_wb_adr_i : m0_wb_adr_i;
                    sel_d   = grant1 ? m1_wb_sel_i : m0_wb_sel_i;
                    wdat_d  = grant1 ? m1_wb_dat_i : m0_wb_dat_i;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue, StWait: begin
                cnt_d = cnt_q + CntWidth'(1);
                // A response only counts once the strobe has been accepted.
                if (state_q == StWait || !s_wb_stall_i) begin
                    if (s_wb_err_i) begin
                        resp_err_d = 1'b1;
                        state_d    = StResp;
                    end else if (s_wb_ack_i) begin
                        resp_err_d = 1'b0;
                        rdat_d     = s_wb_dat_i;
                        state_d    = StResp;
                    end else begin
                        state_d = StWait;
                    end
                end
                if (state_d != StResp && cnt_q == CntLast) begin
                    resp_err_d = 1'b1;
                    state_d    = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            resp_err_q <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            sel_q      <= '0;
            wdat_q     <= '0;
            rdat_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            resp_err_q <= resp_err_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            sel_q      <= sel_d;
            wdat_q     <= wdat_d;
            rdat_q     <= rdat_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        m0_wb_stall_o = ~(idle & grant0);
        m1_wb_stall_o = ~(idle & grant1);
        // Responses are dropped if the owner has abandoned its cycle.
        m0_wb_ack_o   = (state_q == StResp) & ~owner_q & ~resp_err_q & m0_wb_cyc_i;
        m0_wb_err_o   = (state_q == StResp) & ~owner_q &  resp_err_q & m0_wb_cyc_i;
        m1_wb_ack_o   = (state_q == StResp) &  owner_q & ~resp_err_q & m1_wb_cyc_i;
        m1_wb_err_o   = (state_q == StResp) &  owner_q &  resp_err_q & m1_wb_cyc_i;
        m0_wb_dat_o   = rdat_q;
        m1_wb_dat_o   = rdat_q;
        s_wb_cyc_o    = (state_q == StIssue) | (state_q == StWait);
        s_wb_stb_o    = (state_q == StIssue);
        s_wb_we_o     = we_q;
        s_wb_adr_o    = adr_q;
        s_wb_sel_o    = sel_q;
        s_wb_dat_o    = wdat_q;
    end

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
module tb_wb_rr_arbiter2;

    localparam int AW  = 2;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    cyc, stb, we;
    logic [AW-1:0] adr [2];
    logic [SW-1:0] sel [2];
    logic [DW-1:0] wdat [2];

    logic          m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
    logic [DW-1:0] m0_dat, m1_dat;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_wdat;
    logic          s_ack, s_err, s_stall;
    logic [DW-1:0] s_rdat;

    wb_rr_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_wb_cyc_i(cyc[0]), .m0_wb_stb_i(stb[0]), .m0_wb_adr_i(adr[0]),
        .m0_wb_sel_i(sel[0]), .m0_wb_we_i(we[0]), .m0_wb_dat_i(wdat[0]),
        .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err), .m0_wb_stall_o(m0_stall),
        .m0_wb_dat_o(m0_dat),
        .m1_wb_cyc_i(cyc[1]), .m1_wb_stb_i(stb[1]), .m1_wb_adr_i(adr[1]),
        .m1_wb_sel_i(sel[1]), .m1_wb_we_i(we[1]), .m1_wb_dat_i(wdat[1]),
        .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err), .m1_wb_stall_o(m1_stall),
        .m1_wb_dat_o(m1_dat),
        .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
        .s_wb_adr_o(s_adr), .s_wb_sel_o(s_sel), .s_wb_dat_o(s_wdat),
        .s_wb_ack_i(s_ack), .s_wb_err_i(s_err), .s_wb_stall_i(s_stall),
        .s_wb_dat_i(s_rdat)
    );

    // kind: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout)
    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [SW-1:0] sel;
        logic [DW-1:0] wdat;
        int            stalls;
        int            delay;
        int            kind;
        logic [DW-1:0] rdat;
        bit            late;
    } plan_t;

    typedef struct {
        int            master;
        bit            err;
        logic [DW-1:0] dat;
        bit            tmo;
    } exp_t;

    plan_t         plan_q[$];
    exp_t          exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] model_dat = '0;
    int            model_last = 1;
    int            cyc_cnt = 0;
    int            issue_cyc = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic plan_t mk_plan(input logic [AW-1:0] a, input logic w,
                                      input logic [DW-1:0] wd, input int st, input int dl,
                                      input int k, input logic [DW-1:0] rd, input bit lt);
        plan_t p;
        p.adr = a; p.we = w; p.sel = SW'($urandom); p.wdat = wd;
        p.stalls = st; p.delay = dl; p.kind = k; p.rdat = rd; p.late = lt;
        return p;
    endfunction

    function automatic plan_t rand_plan();
        int r;
        r = int'($urandom_range(0, 9));
        return mk_plan(AW'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 4)), (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3,
                       $urandom, 1'b0);
    endfunction

    // Reference: any error leaves the read-data register untouched, a clean ack loads it.
    function automatic exp_t model(input int m, input plan_t p);
        exp_t e;
        e.master = m;
        e.err    = (p.kind != 0);
        e.tmo    = (p.kind == 3);
        if (!e.err) model_dat = p.rdat;
        e.dat    = model_dat;
        return e;
    endfunction

    task automatic master_txn(input int id, input plan_t p);
        int n;
        cyc[id] = 1'b1; stb[id] = 1'b1; adr[id] = p.adr;
        we[id] = p.we; sel[id] = p.sel; wdat[id] = p.wdat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((id == 1 ? m1_stall : m0_stall) && n < 200);
        if (n >= 200) begin
            chk($sformatf("m%0d_grant_bound", id), 64'd1, 64'd0);
            cyc[id] = 1'b0; stb[id] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        stb[id] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id == 1 ? (m1_ack | m1_err) : (m0_ack | m0_err)) && n < 200);
        if (n >= 200) chk($sformatf("m%0d_resp_bound", id), 64'd1, 64'd0);
        @(posedge clk); #1;
        cyc[id] = 1'b0;
    endtask

    task automatic do_round(input bit r0, input bit r1, input plan_t p0, input plan_t p1);
        int first;
        if (r0 && r1) begin
            first = (model_last == 1) ? 0 : 1;
            plan_q.push_back(first == 0 ? p0 : p1);
            exp_q.push_back(model(first, first == 0 ? p0 : p1));
            plan_q.push_back(first == 0 ? p1 : p0);
            exp_q.push_back(model(1 - first, first == 0 ? p1 : p0));
            model_last = 1 - first;
        end else begin
            first = r0 ? 0 : 1;
            plan_q.push_back(r0 ? p0 : p1);
            exp_q.push_back(model(first, r0 ? p0 : p1));
            model_last = first;
        end
        @(posedge clk); #1;
        fork
            if (r0) master_txn(0, p0);
            if (r1) master_txn(1, p1);
        join
    endtask

    // Slave responder: follows the plan queue in the order transfers are expected to appear.
    initial begin
        plan_t p;
        bool_alive: begin end
        s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_rdat = '0;
        forever begin
            @(negedge clk);
            if (rst_n && s_cyc && s_stb) begin
                bit alive;
                int n;
                if (plan_q.size() == 0) begin
                    chk("unexpected_slave_txn", 64'd1, 64'd0);
                    continue;
                end
                p = plan_q.pop_front();
                issue_cyc = cyc_cnt;
                chk("s_adr", 64'(s_adr), 64'(p.adr));
                chk("s_we", 64'(s_we), 64'(p.we));
                chk("s_sel", 64'(s_sel), 64'(p.sel));
                if (p.we) chk("s_wdat", 64'(s_wdat), 64'(p.wdat));
                alive = 1'b1;
                for (int i = 0; i <= p.stalls; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        if (!rst_n) begin
                            alive = 1'b0;
                            break;
                        end
                        chk("s_stb_held", 64'(s_stb), 64'd1);
                        chk("s_adr_stable", 64'(s_adr), 64'(p.adr));
                    end
                    s_stall = (i < p.stalls);
                end
                if (alive && p.kind == 3) begin
                    n = 0;
                    while (rst_n && s_cyc && n < 40) begin
                        @(negedge clk);
                        n++;
                    end
                    if (p.late) begin
                        while (cyc_cnt < issue_cyc + 20) @(negedge clk);
                        s_ack = 1'b1; s_rdat = p.rdat;
                        @(negedge clk);
                        s_ack = 1'b0;
                    end
                end else if (alive) begin
                    for (int d = 1; d <= p.delay; d++) begin
                        @(negedge clk);
                        if (!rst_n) begin
                            alive = 1'b0;
                            break;
                        end
                        if (d == 1) chk("s_stb_dropped", 64'(s_stb), 64'd0);
                    end
                    if (alive) begin
                        s_ack = (p.kind != 1); s_err = (p.kind != 0); s_rdat = p.rdat;
                        @(negedge clk);
                        s_ack = 1'b0; s_err = 1'b0;
                    end
                end
                s_stall = 1'b0;
            end
        end
    end

    // Monitor: every master-side response is matched against the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (m0_ack || m0_err || m1_ack || m1_err)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_master", (m1_ack | m1_err) ? 64'd1 : 64'd0, 64'(e.master));
                    chk("resp_single", 64'(int'(m0_ack) + int'(m0_err) + int'(m1_ack)
                                           + int'(m1_err)), 64'd1);
                    chk("resp_err", 64'(m0_err | m1_err), 64'(e.err));
                    chk("resp_dat", 64'(e.master == 1 ? m1_dat : m0_dat), 64'(e.dat));
                    if (e.tmo) chk("timeout_latency", 64'(cyc_cnt - issue_cyc), 64'(TMO));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        plan_t pa, pb;
        int n;
        cyc = '0; stb = '0; we = '0;
        for (int i = 0; i < 2; i++) begin
            adr[i] = '0; sel[i] = '0; wdat[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_s_cyc", 64'(s_cyc), 64'd0);
        chk("rst_s_stb", 64'(s_stb), 64'd0);
        chk("rst_s_we", 64'(s_we), 64'd0);
        chk("rst_s_adr", 64'(s_adr), 64'd0);
        chk("rst_m0_stall", 64'(m0_stall), 64'd1);
        chk("rst_m1_stall", 64'(m1_stall), 64'd1);
        chk("rst_acks", 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'd0);
        chk("rst_dat", 64'(m0_dat), 64'd0);

        // Simultaneous reads from reset: m0 first, then m1.
        do_round(1'b1, 1'b1, mk_plan(2'd1, 1'b0, '0, 0, 1, 0, 32'h11, 1'b0),
                 mk_plan(2'd2, 1'b0, '0, 0, 1, 0, 32'h22, 1'b0));
        // Single m0 write, ack one cycle after the strobe.
        do_round(1'b1, 1'b0, mk_plan(2'd0, 1'b1, 32'hA5A5_0001, 0, 1, 0, 32'h0, 1'b0),
                 mk_plan(2'd0, 1'b0, '0, 0, 0, 0, '0, 1'b0));
        // Continuous contention: grants alternate.
        repeat (3) do_round(1'b1, 1'b1, rand_plan(), rand_plan());
        // Slave stalls the strobe three cycles.
        do_round(1'b0, 1'b1, mk_plan(2'd0, 1'b0, '0, 0, 0, 0, '0, 1'b0),
                 mk_plan(2'd3, 1'b1, 32'hDEAD_BEEF, 3, 2, 0, 32'h3333, 1'b0));
        // Timeout on m1 with a late ack that must be ignored.
        do_round(1'b0, 1'b1, mk_plan(2'd0, 1'b0, '0, 0, 0, 0, '0, 1'b0),
                 mk_plan(2'd2, 1'b0, '0, 0, 0, 3, 32'h7777, 1'b1));
        repeat (8) begin
            @(negedge clk);
            chk("late_ack_ignored", 64'(m0_ack | m1_ack | s_cyc), 64'd0);
        end
        // Slave error on a read: data output keeps its previous value.
        do_round(1'b1, 1'b0, mk_plan(2'd1, 1'b0, '0, 0, 2, 1, 32'h9999, 1'b0),
                 mk_plan(2'd0, 1'b0, '0, 0, 0, 0, '0, 1'b0));

        // Reset while the slave cycle is in WAIT.
        pa = mk_plan(2'd3, 1'b0, '0, 0, 10, 0, 32'h5555, 1'b0);
        plan_q.push_back(pa);
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = pa.adr; we[0] = pa.we; sel[0] = pa.sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m0_stall && n < 50);
        chk("rst_test_grant", 64'(m0_stall), 64'd0);
        @(posedge clk); #1;
        stb[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        #1;
        chk("wait_s_cyc", 64'(s_cyc), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_s_cyc", 64'(s_cyc), 64'd0);
        chk("rst_async_m0_stall", 64'(m0_stall), 64'd1);
        chk("rst_async_m1_stall", 64'(m1_stall), 64'd1);
        cyc = '0; stb = '0;
        model_last = 1;
        model_dat = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pb = mk_plan(2'd1, 1'b0, '0, 1, 1, 0, 32'hABCD, 1'b0);
        do_round(1'b0, 1'b1, pb, pb);

        // Randomized traffic.
        repeat (60) begin
            int r;
            r = int'($urandom_range(1, 3));
            do_round(r[0], r[1], rand_plan(), rand_plan());
        end

        repeat (5) @(negedge clk);
        chk("exp_drained", 64'(exp_q.size()), 64'd0);
        chk("plan_drained", 64'(plan_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
